// File: rtl/auto_player.sv
// auto_player: automated responder for the LED-guessing game.
// It presses the lit button after a programmable delay and can deliberately miss every Nth press.
module auto_player #(
    parameter int DELAY_W = 27,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DELAY_W-1:0] delay,
    input  logic [3:0]         miss_every,
    input  logic [3:0]         y,
    input  logic               win,
    input  logic               lose,
    output logic [3:0]         b,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   presses,
    output logic [CNT_W-1:0]   misses
);
    typedef enum logic [2:0] {IDLE, WAIT, PRESS, HOLD, DONE} state_t;
    state_t state, state_n;
    logic [3:0] target, target_n, phase, phase_n, b_n;
    logic [DELAY_W-1:0] dly, dly_n, cnt, cnt_n;
    logic [CNT_W-1:0] presses_n, misses_n;
    logic y_onehot, miss;
    assign y_onehot = (y != 4'd0) && ((y & (y - 4'd1)) == 4'd0);
    assign miss = (miss_every != 4'd0) && (phase == miss_every - 4'd1);
    assign busy = (state == WAIT) || (state == PRESS) || (state == HOLD);
    assign done = (state == DONE);
    always_comb begin
        state_n   = state;
        target_n  = target;
        dly_n     = dly;
        cnt_n     = cnt;
        phase_n   = phase;
        b_n       = 4'd0;
        presses_n = presses;
        misses_n  = misses;
        if (!en) state_n = IDLE;
        else if (win || lose) state_n = DONE;
        else case (state)
            IDLE: if (y_onehot) begin
                state_n  = WAIT;
                target_n = y;
                dly_n    = delay;
                cnt_n    = '0;
            end
            WAIT: if (y != target) state_n = IDLE;
            else if (cnt == dly) begin
                // a miss presses the neighbouring button so the game sees a wrong guess
                state_n   = PRESS;
                b_n       = miss ? {target[2:0], target[3]} : target;
                phase_n   = (miss || miss_every == 4'd0) ? 4'd0 : phase + 4'd1;
                presses_n = (presses == '1) ? presses : presses + CNT_W'(1);
                misses_n  = (!miss || misses == '1) ? misses : misses + CNT_W'(1);
            end
            else cnt_n = cnt + DELAY_W'(1);
            PRESS: state_n = HOLD;
            HOLD: if (y != target) state_n = IDLE;
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            target  <= 4'd0;
            dly     <= '0;
            cnt     <= '0;
            phase   <= 4'd0;
            b       <= 4'd0;
            presses <= '0;
            misses  <= '0;
        end else begin
            state   <= state_n;
            target  <= target_n;
            dly     <= dly_n;
            cnt     <= cnt_n;
            phase   <= phase_n;
            b       <= b_n;
            presses <= presses_n;
            misses  <= misses_n;
        end
    end
endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player: scoreboard bench for auto_player.
// Expected ticks (value and arrival cycle) are queued by the stimulus and consumed by a monitor.
module tb_auto_player;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [26:0] delay;
    logic [3:0]  miss_every;
    logic [3:0]  y;
    logic        win;
    logic        lose;
    logic [3:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  presses;
    logic [7:0]  misses;
    typedef struct {logic [3:0] val; int cyc;} tick_t;
    tick_t exp_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    auto_player dut (
        .clk(clk), .rst_n(rst_n), .en(en), .delay(delay), .miss_every(miss_every),
        .y(y), .win(win), .lose(lose), .b(b), .busy(busy), .done(done),
        .presses(presses), .misses(misses)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // monitor: every nonzero b must match the head of the queue in value and cycle
    always @(negedge clk) begin
        if (b != 4'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: got b=%b at cycle %0d, required none", b, cyc);
            end else begin
                tick_t t;
                t = exp_q.pop_front();
                if (b !== t.val || cyc != t.cyc) begin
                    errors++;
                    $display("FAIL tick: got b=%b at cycle %0d, required b=%b at cycle %0d", b, cyc, t.val, t.cyc);
                end
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask
    task automatic steps(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic expect_tick(input logic [3:0] v, input int dly);
        tick_t t;
        t.val = v;
        t.cyc = cyc + dly + 2;
        exp_q.push_back(t);
    endtask
    logic [3:0] tgts [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] exps [4] = '{4'b0001, 4'b0100, 4'b0100, 4'b0001};
    initial begin
        rst_n = 1'b0; en = 1'b1; delay = 27'd3; miss_every = 4'd0;
        y = 4'b0100; win = 1'b0; lose = 1'b0;
        steps(2);
        chk("reset_b", 32'(b), 32'd0);
        chk("reset_presses", 32'(presses), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_misses", 32'(misses), 32'd0);
        rst_n = 1'b1;
        expect_tick(4'b0100, 3);
        steps(1);
        chk("t1_wait_busy", 32'(busy), 32'd1);
        steps(7);
        chk("t1_presses", 32'(presses), 32'd1);
        chk("t1_hold_busy", 32'(busy), 32'd1);
        y = 4'b0000;
        steps(2);
        chk("t1_idle", 32'(busy), 32'd0);
        delay = 27'd0; y = 4'b0001;
        expect_tick(4'b0001, 0);
        steps(3);
        y = 4'b0011;
        steps(3);
        chk("t2_multihot_busy", 32'(busy), 32'd0);
        chk("t2_presses", 32'(presses), 32'd2);
        miss_every = 4'd2; delay = 27'd1;
        for (int i = 0; i < 4; i++) begin
            y = tgts[i];
            expect_tick(exps[i], 1);
            steps(4);
            y = 4'b0000;
            steps(2);
        end
        chk("t3_presses", 32'(presses), 32'd6);
        chk("t3_misses", 32'(misses), 32'd2);
        miss_every = 4'd0; delay = 27'd10; y = 4'b0010;
        steps(6);
        y = 4'b1000;
        expect_tick(4'b1000, 11);
        steps(15);
        chk("t4_presses", 32'(presses), 32'd7);
        y = 4'b0000;
        steps(2);
        delay = 27'd2; y = 4'b0100;
        steps(3);
        win = 1'b1;
        steps(2);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_presses", 32'(presses), 32'd7);
        chk("t5_busy", 32'(busy), 32'd0);
        win = 1'b0;
        steps(3);
        chk("t5_done_held", 32'(done), 32'd1);
        en = 1'b0; y = 4'b0000;
        steps(2);
        chk("t5_idle_done", 32'(done), 32'd0);
        en = 1'b1; delay = 27'd5; y = 4'b0010;
        steps(3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_b", 32'(b), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_presses", 32'(presses), 32'd0);
        chk("t6_misses", 32'(misses), 32'd0);
        y = 4'b0000;
        #1 rst_n = 1'b1;
        steps(10);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        chk("t6_no_press", 32'(presses), 32'd0);
        while (exp_q.size() != 0) begin
            tick_t t;
            t = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL tick_missing: got no tick, required b=%b at cycle %0d", t.val, t.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
